// File: rtl/tf_delay_line.sv
// tf_delay_line
//   Run-time configurable delay line that carries N_CH twiddle factors plus
//   the modulus from the twiddle generator to the butterfly array, so that
//   they line up with butterfly data whose latency depends on the NTT mode.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        synchronous active-low reset
//   en_i          pipeline advance; low holds every stage
//   flush_i       clear all stages (delay unchanged, input dropped)
//   cfg_load_i    load cfg_delay_i (clamped to MAX_DEPTH) and clear all stages
//   cfg_delay_i   requested delay in cycles
//   in_valid_i    qualifier for tf_in_i / mod_in_i
//   tf_in_i       twiddle channel k at bits [k*D_WIDTH +: D_WIDTH]
//   mod_in_i      modulus
//   out_valid_o   qualifier for tf_out_o / mod_out_o
//   tf_out_o      delayed twiddle channels, same packing as tf_in_i
//   mod_out_o     delayed modulus
//   delay_q_o     currently active delay
module tf_delay_line #(
  parameter int unsigned D_WIDTH       = 32,
  parameter int unsigned N_CH          = 16,
  parameter int unsigned MAX_DEPTH     = 8,
  parameter int unsigned DEFAULT_DELAY = 5,
  localparam int unsigned DW           = $clog2(MAX_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      cfg_load_i,
  input  logic [DW-1:0]             cfg_delay_i,
  input  logic                      in_valid_i,
  input  logic [N_CH*D_WIDTH-1:0]   tf_in_i,
  input  logic [D_WIDTH-1:0]        mod_in_i,
  output logic                      out_valid_o,
  output logic [N_CH*D_WIDTH-1:0]   tf_out_o,
  output logic [D_WIDTH-1:0]        mod_out_o,
  output logic [DW-1:0]             delay_q_o
);

  localparam int unsigned TW = N_CH * D_WIDTH;
  localparam logic [DW-1:0] MaxDelay = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DefDelay = DW'(DEFAULT_DELAY);

  typedef struct packed {
    logic               valid;
    logic [TW-1:0]      tf;
    logic [D_WIDTH-1:0] modulus;
  } stage_t;

  // Index 0 is the first stage (one cycle of delay), index k holds k+1.
  stage_t [MAX_DEPTH-1:0] stage_q, stage_d;
  logic   [DW-1:0]        delay_q, delay_d;
  stage_t                 sel;

  // Next-state: cfg_load > flush > en > hold.
  always_comb begin
    delay_d = delay_q;
    stage_d = stage_q;
    if (cfg_load_i) begin
      delay_d = (cfg_delay_i > MaxDelay) ? MaxDelay : cfg_delay_i;
      stage_d = '0;
    end else if (flush_i) begin
      stage_d = '0;
    end else if (en_i) begin
      for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      // Bubbles enter with zero data so empty stages never carry stale values.
      stage_d[0] = '0;
      if (in_valid_i) begin
        stage_d[0].valid   = 1'b1;
        stage_d[0].tf      = tf_in_i;
        stage_d[0].modulus = mod_in_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      delay_q <= DefDelay;
      stage_q <= '0;
    end else begin
      delay_q <= delay_d;
      stage_q <= stage_d;
    end
  end

  // Output tap: delay 0 is a pure combinational bypass of the inputs;
  // otherwise the tap is stage delay_q (compared per stage to keep the
  // select free of index-width truncation).
  always_comb begin
    sel = '0;
    if (delay_q == '0) begin
      if (in_valid_i) begin
        sel.valid   = 1'b1;
        sel.tf      = tf_in_i;
        sel.modulus = mod_in_i;
      end
    end else begin
      for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
        if (delay_q == DW'(k + 1)) begin
          sel = stage_q[k];
        end
      end
    end
  end

  assign out_valid_o = sel.valid;
  assign tf_out_o    = sel.valid ? sel.tf : '0;
  assign mod_out_o   = sel.valid ? sel.modulus : '0;
  assign delay_q_o   = delay_q;

endmodule

// File: tb/tb_tf_delay_line.sv
module tb_tf_delay_line;

  localparam int unsigned D_WIDTH   = 32;
  localparam int unsigned N_CH      = 16;
  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned DW        = 4;
  localparam int unsigned TW        = N_CH * D_WIDTH;
  localparam logic [31:0] MODC      = 32'h3FFF_FFF1;

  logic               clk = 1'b0;
  logic               rst_n, en, flush, cfg_load, in_valid;
  logic [DW-1:0]      cfg_delay;
  logic [TW-1:0]      tf_in;
  logic [D_WIDTH-1:0] mod_in;
  logic               out_valid;
  logic [TW-1:0]      tf_out;
  logic [D_WIDTH-1:0] mod_out;
  logic [DW-1:0]      delay_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tf_delay_line #(
    .D_WIDTH(D_WIDTH), .N_CH(N_CH), .MAX_DEPTH(MAX_DEPTH), .DEFAULT_DELAY(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .cfg_load_i(cfg_load), .cfg_delay_i(cfg_delay), .in_valid_i(in_valid),
    .tf_in_i(tf_in), .mod_in_i(mod_in), .out_valid_o(out_valid),
    .tf_out_o(tf_out), .mod_out_o(mod_out), .delay_q_o(delay_q)
  );

  // ---------------- reference model: history of accepted en-cycles -------
  typedef struct packed {
    logic               v;
    logic [TW-1:0]      tf;
    logic [D_WIDTH-1:0] m;
  } ent_t;

  ent_t        hist[$];
  int unsigned mdelay = 5;

  task automatic model_edge();
    ent_t e;
    if (!rst_n) begin
      hist.delete();
      mdelay = 5;
    end else if (cfg_load) begin
      hist.delete();
      mdelay = (int'(cfg_delay) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_delay);
    end else if (flush) begin
      hist.delete();
    end else if (en) begin
      e = '0;
      if (in_valid) begin
        e.v = 1'b1; e.tf = tf_in; e.m = mod_in;
      end
      hist.push_back(e);
      if (hist.size() > MAX_DEPTH) void'(hist.pop_front());
    end
  endtask

  // Output = entry pushed mdelay en-cycles ago, or the live input when mdelay = 0.
  task automatic model_out(output ent_t e);
    e = '0;
    if (mdelay == 0) begin
      if (in_valid) begin
        e.v = 1'b1; e.tf = tf_in; e.m = mod_in;
      end
    end else if (hist.size() >= mdelay) begin
      e = hist[hist.size() - mdelay];
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [TW-1:0] gen_tf(input int tag);
    logic [TW-1:0] r;
    for (int k = 0; k < int'(N_CH); k++) r[k*D_WIDTH +: D_WIDTH] = 32'(16 * tag + k);
    return r;
  endfunction

  task automatic check(input string nm, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [TW-1:0] etf,
                           input logic [D_WIDTH-1:0] em, input logic [DW-1:0] ed);
    check({nm, ".valid"}, TW'(out_valid), TW'(ev));
    check({nm, ".tf"},    tf_out, etf);
    check({nm, ".mod"},   TW'(mod_out), TW'(em));
    check({nm, ".delay"}, TW'(delay_q), TW'(ed));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst_n, en, flush, cfg;
    logic [DW-1:0] cfgd;
    logic          iv;
    int            tag;
    logic          chk, ev;
    int            etag;
    logic [DW-1:0] edly;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic f, input logic c,
                     input int cd, input logic iv, input int tag, input logic chk,
                     input logic ev, input int etag, input int edly);
    vec_t v;
    v.rst_n = r; v.en = e; v.flush = f; v.cfg = c; v.cfgd = DW'(cd); v.iv = iv;
    v.tag = tag; v.chk = chk; v.ev = ev; v.etag = etag; v.edly = DW'(edly);
    tbl.push_back(v);
  endtask

  initial begin
    int p;
    ent_t em;
    logic en_c, iv_c;

    rst_n = 1'b0; en = 1'b0; flush = 1'b0; cfg_load = 1'b0; cfg_delay = '0;
    in_valid = 1'b0; tf_in = '0; mod_in = '0;

    // Reset with busy inputs; rst must win over cfg_load (delay stays 5).
    add(0, 1, 0, 0, 0, 1, 7, 0, 0, 0, 5);
    add(0, 1, 0, 1, 3, 1, 8, 1, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
    // Stream at default delay 5, then drain.
    for (int n = 0; n < 20; n++) add(1, 1, 0, 0, 0, 1, n, 1, n >= 5, n - 5, 5);
    for (int m = 20; m < 26; m++) add(1, 1, 0, 0, 0, 0, 0, 1, m <= 24, m - 5, 5);
    // Stall at cycles 3, 4, 9: output is the 5th most recent push.
    p = 0;
    for (int c = 0; c < 29; c++) begin
      en_c = !(c == 3 || c == 4 || c == 9);
      iv_c = (c <= 22);
      add(1, en_c, 0, 0, 0, iv_c, (c < 3) ? c : ((c < 9) ? c - 2 : c - 3), 1,
          (p >= 5) && (p - 5 < 20), p - 5, 5);
      if (en_c) p++;
    end
    // Reconfigure to delay 2 at cycle 10; sample 10 is dropped.
    for (int c = 0; c < 23; c++)
      add(1, 1, 0, c == 10, 2, c <= 19, c, 1,
          (c <= 10) ? (c >= 5) : (c >= 13 && c <= 21),
          (c <= 10) ? c - 5 : c - 2, (c <= 10) ? 5 : 2);
    // Clamp: request 15, get 8.
    for (int c = 0; c < 20; c++)
      add(1, 1, 0, c == 0, 15, c >= 1 && c <= 10, c - 1, 1,
          c >= 9 && c <= 18, c - 9, (c == 0) ? 2 : 8);
    // Bypass (delay 0): outputs follow inputs regardless of en/flush.
    add(1, 1, 0, 1, 0, 1, 60, 1, 0, 0, 8);
    for (int c = 1; c <= 8; c++)
      add(1, (c % 2) == 1, c == 4, c == 8, 3, (c % 3) != 0, 100 + c, 1,
          (c % 3) != 0, 100 + c, 0);
    // Delay 3, then flush together with en/in_valid: tag 50 must never appear.
    for (int c = 0; c < 4; c++) add(1, 1, 0, 0, 0, 1, c, 1, c == 3, 0, 3);
    add(1, 1, 1, 0, 0, 1, 50, 1, 1, 1, 3);
    for (int c = 5; c < 10; c++) add(1, 1, 0, 0, 0, 0, 50, 1, 0, 0, 3);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; en = tbl[i].en; flush = tbl[i].flush;
      cfg_load = tbl[i].cfg; cfg_delay = tbl[i].cfgd; in_valid = tbl[i].iv;
      tf_in = gen_tf(tbl[i].tag); mod_in = MODC;
      #1;
      if (tbl[i].chk)
        check_out($sformatf("vec%0d", i), tbl[i].ev,
                  tbl[i].ev ? gen_tf(tbl[i].etag) : '0,
                  tbl[i].ev ? MODC : '0, tbl[i].edly);
      @(posedge clk);
      #1 model_edge();
    end

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 63) != 0);
      cfg_load  = ($urandom_range(0, 15) == 0);
      cfg_delay = DW'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 19) == 0);
      en        = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < int'(N_CH); k++) tf_in[k*D_WIDTH +: D_WIDTH] = $urandom;
      mod_in = $urandom;
      #1;
      model_out(em);
      check_out($sformatf("rnd%0d", i), em.v, em.tf, em.m, DW'(mdelay));
      @(posedge clk);
      #1 model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
